cache_controller: RTL and testbench



---
 rtl/cache_controller.sv | 205 ++++++++++++++++++++
 tb/tb_cache_controller.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Two-way set-associative, write-back, write-allocate byte cache.
// 2 sets x 2 ways x 1 byte; index = address[0], tag = address[7:1].
// Hits and clean write misses complete in one cycle; other misses evict
// the victim (writing it back if dirty) and fill over a req/ack handshake.
module cache_controller (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic       write,
  input  logic [7:0] address,
  input  logic [7:0] dataIn,
  output logic [7:0] dataOut,
  output logic       ready,
  output logic       hit,
  output logic       busy,
  output logic       mem_req,
  output logic       mem_write,
  output logic [7:0] mem_address,
  output logic [7:0] mem_dataIn,
  input  logic [7:0] mem_dataOut,
  input  logic       mem_ack,
  output logic [7:0] hit_count,
  output logic [7:0] miss_count
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;

  state_t     state, state_nx;

  // line storage indexed [set][way]; lru names the way to evict next
  logic       valid [2][2];
  logic       dirty [2][2];
  logic [6:0] tags  [2][2];
  logic [7:0] data  [2][2];
  logic       lru   [2];

  // request latched when a miss needs the memory
  logic       lat_write;
  logic [7:0] lat_addr;
  logic [7:0] lat_data;
  logic       lat_way;
  logic       lidx;

  // lookup of the incoming request
  logic       idx;
  logic [6:0] rtag;
  logic       hit0, hit1, any_hit, hit_way;
  logic       vict, vict_dirty;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // tag compare on both ways and victim selection (invalid way 0, then 1, else LRU)
  always_comb begin
    idx        = address[0];
    rtag       = address[7:1];
    lidx       = lat_addr[0];
    hit0       = valid[idx][0] && (tags[idx][0] == rtag);
    hit1       = valid[idx][1] && (tags[idx][1] == rtag);
    any_hit    = hit0 || hit1;
    hit_way    = !hit0;
    vict       = lru[idx];
    if (!valid[idx][0])
      vict = 1'b0;
    else if (!valid[idx][1])
      vict = 1'b1;
    vict_dirty = valid[idx][vict] && dirty[idx][vict];
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next-state and memory handshake strobes
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (req && !any_hit) begin
          if (vict_dirty)
            state_nx = WRITEBACK;
          else if (!write)
            state_nx = FILL;
        end
      end
      WRITEBACK: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (mem_ack)
          state_nx = lat_write ? RESPOND : FILL;
      end
      FILL: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack)
          state_nx = RESPOND;
      end
      RESPOND: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // line updates, response registers, memory address/data and counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid       <= '{default: '0};
      dirty       <= '{default: '0};
      tags        <= '{default: '0};
      data        <= '{default: '0};
      lru         <= '{default: '0};
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_way     <= 1'b0;
      dataOut     <= '0;
      ready       <= 1'b0;
      hit         <= 1'b0;
      mem_address <= '0;
      mem_dataIn  <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      ready <= 1'b0;
      hit   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (any_hit) begin
              ready     <= 1'b1;
              hit       <= 1'b1;
              lru[idx]  <= ~hit_way;
              hit_count <= sat_inc(hit_count);
              if (write) begin
                data[idx][hit_way]  <= dataIn;
                dirty[idx][hit_way] <= 1'b1;
              end else begin
                dataOut <= data[idx][hit_way];
              end
            end else begin
              lat_write <= write;
              lat_addr  <= address;
              lat_data  <= dataIn;
              lat_way   <= vict;
              if (vict_dirty) begin
                mem_address <= {tags[idx][vict], idx};
                mem_dataIn  <= data[idx][vict];
              end else if (!write) begin
                mem_address <= address;
              end else begin
                valid[idx][vict] <= 1'b1;
                dirty[idx][vict] <= 1'b1;
                tags[idx][vict]  <= rtag;
                data[idx][vict]  <= dataIn;
                lru[idx]         <= ~vict;
                ready            <= 1'b1;
                miss_count       <= sat_inc(miss_count);
              end
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            if (lat_write) begin
              valid[lidx][lat_way] <= 1'b1;
              dirty[lidx][lat_way] <= 1'b1;
              tags[lidx][lat_way]  <= lat_addr[7:1];
              data[lidx][lat_way]  <= lat_data;
              lru[lidx]            <= ~lat_way;
            end else begin
              mem_address <= lat_addr;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid[lidx][lat_way] <= 1'b1;
            dirty[lidx][lat_way] <= 1'b0;
            tags[lidx][lat_way]  <= lat_addr[7:1];
            data[lidx][lat_way]  <= mem_dataOut;
            lru[lidx]            <= ~lat_way;
            dataOut              <= mem_dataOut;
          end
        end
        RESPOND: begin
          ready      <= 1'b1;
          miss_count <= sat_inc(miss_count);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus a
// randomized phase, checked against an address-indexed LRU cache model.
module tb_cache_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       req = 1'b0;
  logic       write = 1'b0;
  logic [7:0] address = '0;
  logic [7:0] dataIn = '0;
  logic [7:0] dataOut;
  logic       ready, hit, busy;
  logic       mem_req, mem_write;
  logic [7:0] mem_address, mem_dataIn;
  logic [7:0] mem_dataOut = '0;
  logic       mem_ack = 1'b0;
  logic [7:0] hit_count, miss_count;

  cache_controller dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .write       (write),
    .address     (address),
    .dataIn      (dataIn),
    .dataOut     (dataOut),
    .ready       (ready),
    .hit         (hit),
    .busy        (busy),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut),
    .mem_ack     (mem_ack),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } op_t;

  int checks = 0;
  int errors = 0;

  // backing memory served by the bench, and the model's view of it
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  // reference cache: residency, data, dirtiness and last-use time per address
  bit         c_in    [256];
  bit         c_dirty [256];
  logic [7:0] c_data  [256];
  int         c_last  [256];
  int         tick;
  int         m_hits, m_misses;
  logic [7:0] last_dout;
  op_t        exp_q[$];
  op_t        obs_q[$];

  // results of the most recent access
  logic       got_ready, got_hit;
  logic [7:0] got_dout;
  int         got_cycles;
  bit         got_unstable;

  logic [7:0] pool [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'hFE, 8'hFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      c_in[i]    = 1'b0;
      c_dirty[i] = 1'b0;
      c_data[i]  = '0;
      c_last[i]  = 0;
    end
    tick      = 0;
    m_hits    = 0;
    m_misses  = 0;
    last_dout = '0;
  endtask

  // each set holds at most two addresses; a miss on a full set evicts the
  // least recently used one
  task automatic model_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                              output logic eh, output logic [7:0] ed);
    int         nres;
    int         oldest;
    logic [7:0] vic;
    logic [7:0] ia;
    tick++;
    ed = '0;
    if (c_in[a]) begin
      eh = 1'b1;
      ed = c_data[a];
      if (w) begin
        c_data[a]  = d;
        c_dirty[a] = 1'b1;
      end
      c_last[a] = tick;
      if (m_hits < 255) m_hits++;
      return;
    end
    eh     = 1'b0;
    nres   = 0;
    oldest = 32'h7fffffff;
    vic    = '0;
    for (int i = 0; i < 256; i++) begin
      ia = 8'(i);
      if (c_in[ia] && ia[0] == a[0]) begin
        nres++;
        if (c_last[ia] < oldest) begin
          oldest = c_last[ia];
          vic    = ia;
        end
      end
    end
    if (nres == 2) begin
      if (c_dirty[vic]) begin
        exp_q.push_back('{1'b1, vic, c_data[vic]});
        ref_mem[vic] = c_data[vic];
      end
      c_in[vic]    = 1'b0;
      c_dirty[vic] = 1'b0;
    end
    c_in[a] = 1'b1;
    if (w) begin
      c_dirty[a] = 1'b1;
      c_data[a]  = d;
    end else begin
      exp_q.push_back('{1'b0, a, 8'h00});
      c_dirty[a] = 1'b0;
      c_data[a]  = ref_mem[a];
      ed         = ref_mem[a];
    end
    c_last[a] = tick;
    if (m_misses < 255) m_misses++;
  endtask

  // issue one request, act as memory with the given ack latency, wait for ready
  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int lat, input bit spam);
    int  n, k;
    bit  intxn, done;
    op_t first, cur;
    obs_q.delete();
    got_unstable = 1'b0;
    got_ready    = 1'b0;
    got_hit      = 1'b0;
    got_dout     = '0;
    first        = '0;
    req     = 1'b1;
    write   = w;
    address = a;
    dataIn  = d;
    @(posedge clock); #1;
    req   = 1'b0;
    n     = 1;
    k     = 0;
    intxn = 1'b0;
    done  = 1'b0;
    while (!done) begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        intxn   = 1'b0;
      end
      if (ready) begin
        got_ready = 1'b1;
        got_hit   = hit;
        got_dout  = dataOut;
        done      = 1'b1;
        req       = 1'b0;
      end else begin
        if (mem_req) begin
          cur = '{mem_write, mem_address, mem_write ? mem_dataIn : 8'h00};
          if (!intxn) begin
            intxn = 1'b1;
            k     = 1;
            first = cur;
          end else begin
            k++;
            if (cur != first) got_unstable = 1'b1;
          end
          if (k == lat) begin
            if (mem_write) mem[mem_address] = mem_dataIn;
            else           mem_dataOut = mem[mem_address];
            obs_q.push_back(first);
            mem_ack = 1'b1;
          end
        end
        if (spam && busy) begin
          req     = 1'($urandom_range(0, 1));
          address = 8'($urandom);
          write   = 1'($urandom_range(0, 1));
        end else begin
          req = 1'b0;
        end
        if (n >= 100) done = 1'b1;
        else begin
          @(posedge clock); #1;
          n++;
        end
      end
    end
    got_cycles = n;
    mem_ack    = 1'b0;
    req        = 1'b0;
    if (spam) begin
      repeat (3) begin
        @(posedge clock); #1;
        chk("extra_ready", ready, 0);
        chk("extra_mem_req", mem_req, 0);
      end
    end
  endtask

  task automatic run(input logic w, input logic [7:0] a, input logic [7:0] d,
                     input int lat, input bit spam);
    logic       eh;
    logic [7:0] ed, edo;
    int         ops;
    exp_q.delete();
    model_access(w, a, d, eh, ed);
    if (w) edo = last_dout;
    else begin
      edo       = ed;
      last_dout = ed;
    end
    ops = exp_q.size();
    access(w, a, d, lat, spam);
    chk("ready_seen", got_ready, 1);
    chk("hit", got_hit, eh);
    chk("dataOut", got_dout, edo);
    chk("latency", got_cycles, (ops == 0) ? 1 : ops * lat + 2);
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
    chk("mem_op_count", obs_q.size(), ops);
    for (int i = 0; i < ops && i < obs_q.size(); i++)
      chk("mem_op", obs_q[i], exp_q[i]);
    chk("mem_stable", got_unstable, 0);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    req     = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0] ra;

    for (int i = 0; i < 256; i++) mem[8'(i)] = 8'($urandom);
    mem[0] = 8'h05;
    mem[1] = 8'h03;
    mem[2] = 8'h01;
    mem[3] = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[8'(i)] = mem[8'(i)];
    model_reset();

    // asynchronous reset before any clock edge
    #3 reset_n = 1'b0;
    #1;
    chk("rst_dataOut", dataOut, 0);
    chk("rst_ready", ready, 0);
    chk("rst_hit", hit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_dataIn", mem_dataIn, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // read miss then read hit
    run(1'b0, 8'h02, 8'h00, 1, 1'b0);
    chk("first_read_data", got_dout, 8'h01);
    run(1'b0, 8'h02, 8'h00, 1, 1'b0);

    // clean write miss installs without memory traffic
    do_reset();
    run(1'b1, 8'h04, 8'hAA, 1, 1'b0);
    run(1'b0, 8'h04, 8'h00, 1, 1'b0);
    chk("read_after_write", got_dout, 8'hAA);

    // set-0 eviction of a dirty LRU line
    do_reset();
    run(1'b1, 8'h00, 8'h11, 1, 1'b0);
    run(1'b1, 8'h02, 8'h22, 1, 1'b0);
    run(1'b0, 8'h00, 8'h00, 1, 1'b0);
    run(1'b0, 8'h04, 8'h00, 1, 1'b0);
    chk("writeback_mem02", mem[2], 8'h22);

    // slow memory with ignored requests pulsed while busy
    run(1'b0, 8'h10, 8'h00, 5, 1'b1);

    // reset in the middle of a fill
    do_reset();
    req     = 1'b1;
    write   = 1'b0;
    address = 8'h20;
    @(posedge clock); #1;
    req = 1'b0;
    n   = 0;
    while (!(mem_req && !mem_write) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("fill_reached", mem_req & ~mem_write, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("midfill_mem_req", mem_req, 0);
    chk("midfill_busy", busy, 0);
    chk("midfill_ready", ready, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    run(1'b0, 8'h20, 8'h00, 1, 1'b0);

    // randomized mix over a small address pool
    do_reset();
    repeat (200) begin
      ra = pool[$urandom_range(0, 7)];
      run(1'($urandom_range(0, 1)), ra, 8'($urandom), $urandom_range(1, 3), 1'b0);
    end
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[8'(i)] !== ref_mem[8'(i)]) bad++;
    chk("mem_image", bad, 0);

    // hit counter saturation
    do_reset();
    run(1'b0, 8'h02, 8'h00, 1, 1'b0);
    repeat (300) run(1'b0, 8'h02, 8'h00, 1, 1'b0);
    chk("hit_saturated", hit_count, 255);
    chk("miss_unchanged", miss_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
